// File: rtl/voice_arranger.sv
// voice_arranger: buffers up to NUM_VOICES notes, then releases them together for one beat-counted step.
// Define ALLOC_ROUND_ROBIN_EN to start the free-voice search at a rotating pointer.
module voice_arranger #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         beat,
    input  logic [NOTE_W+DUR_W:0]        note_in,
    input  logic                         note_valid,
    input  logic                         play_enable,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*DUR_W-1:0]  voice_duration,
    output logic                         note_ack,
    output logic                         advance_time,
    output logic                         overflow
);
    localparam int PW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    typedef enum logic [2:0] {ASSIGN, LOAD, ADVANCE, PAUSE, RELEASE} state_t;
    state_t state_q, state_d;
    logic [NUM_VOICES-1:0] busy_q, busy_d, pend_q, pend_d;
    logic [DUR_W-1:0] count_q, count_d;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0][DUR_W-1:0] dur_q, dur_d;
    logic ack_q, ack_d, ovf_q, ovf_d;
    logic [PW-1:0] base, idx;
    logic found;
    logic is_adv;
    logic [NOTE_W-1:0] in_note;
    logic [DUR_W-1:0] in_dur;
    assign is_adv  = note_in[NOTE_W+DUR_W];
    assign in_note = note_in[DUR_W +: NOTE_W];
    assign in_dur  = note_in[DUR_W-1:0];
`ifdef ALLOC_ROUND_ROBIN_EN
    logic [PW-1:0] ptr_q;
    always_ff @(posedge clk)
        if (reset) ptr_q <= '0;
        else if (state_q == ASSIGN && note_valid && !is_adv && found)
            ptr_q <= (int'(idx) == NUM_VOICES - 1) ? '0 : idx + 1'b1;
    assign base = ptr_q;
`else
    assign base = '0;
`endif
    // Scan downwards so the first free voice at or after base wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= NUM_VOICES) j -= NUM_VOICES;
            if (!busy_q[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        pend_d       = pend_q | voice_done;
        count_d      = count_q;
        note_d       = note_q;
        dur_d        = dur_q;
        ack_d        = 1'b0;
        ovf_d        = ovf_q;
        voice_load   = '0;
        advance_time = 1'b0;
        case (state_q)
            ASSIGN: if (note_valid) begin
                if (is_adv) begin
                    for (int i = 0; i < NUM_VOICES; i++)
                        if (!busy_q[i]) begin
                            note_d[i] = '0;
                            dur_d[i]  = in_dur;
                        end
                    busy_d  = '1;
                    count_d = (in_dur == '0) ? '0 : in_dur - 1'b1;
                    state_d = LOAD;
                end else begin
                    ack_d = 1'b1;
                    if (found) begin
                        note_d[idx] = in_note;
                        dur_d[idx]  = in_dur;
                        busy_d[idx] = 1'b1;
                    end else ovf_d = 1'b1;
                end
            end
            LOAD: begin
                voice_load = '1;
                state_d    = ADVANCE;
            end
            ADVANCE: begin
                advance_time = 1'b1;
                if (beat && count_q == '0) begin
                    state_d = RELEASE;
                    ack_d   = 1'b1;
                end else if (!play_enable) begin
                    advance_time = 1'b0;
                    state_d      = PAUSE;
                end else if (beat) count_d = count_q - 1'b1;
            end
            PAUSE: state_d = play_enable ? ADVANCE : PAUSE;
            RELEASE: begin
                busy_d  = busy_q & ~pend_q;
                pend_d  = voice_done;
                state_d = ASSIGN;
            end
            default: state_d = ASSIGN;
        endcase
    end
    always_ff @(posedge clk)
        if (reset) begin
            state_q <= ASSIGN;
            busy_q  <= '0;
            pend_q  <= '0;
            count_q <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    assign voice_note     = note_q;
    assign voice_duration = dur_q;
    assign note_ack       = ack_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_voice_arranger.sv
// tb_voice_arranger: directed vectors with hand-computed expectations for voice_arranger (N=3, 6-bit fields).
module tb_voice_arranger;
    localparam int N = 3, NW = 6, DW = 6;
    logic clk = 1'b0, reset, beat, note_valid, play_enable;
    logic [NW+DW:0] note_in;
    logic [N-1:0] voice_done, voice_load;
    logic [N*NW-1:0] voice_note;
    logic [N*DW-1:0] voice_duration;
    logic note_ack, advance_time, overflow;
    int n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    voice_arranger #(.NUM_VOICES(N), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk(clk), .reset(reset), .beat(beat), .note_in(note_in), .note_valid(note_valid),
        .play_enable(play_enable), .voice_done(voice_done), .voice_load(voice_load),
        .voice_note(voice_note), .voice_duration(voice_duration), .note_ack(note_ack),
        .advance_time(advance_time), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] vn(input int v0, input int v1, input int v2);
        return 32'((v2 << 12) | (v1 << 6) | v0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic adv, input int nt, input int d);
        note_in    = {adv, 6'(nt), 6'(d)};
        note_valid = 1'b1;
        tick;
        note_valid = 1'b0;
    endtask

    task automatic pulse_beat;
        beat = 1'b1;
        tick;
        beat = 1'b0;
    endtask

    initial begin
        reset = 1'b1; beat = 1'b0; note_valid = 1'b0; play_enable = 1'b1;
        voice_done = '0; note_in = '0;
        tick; tick;
        reset = 1'b0;
        check("rst_note", 32'(voice_note), 0);
        check("rst_dur", 32'(voice_duration), 0);
        check("rst_load", 32'(voice_load), 0);
        check("rst_ack", 32'(note_ack), 0);
        check("rst_adv", 32'(advance_time), 0);
        check("rst_ovf", 32'(overflow), 0);

        send(1'b0, 12, 4);
        check("ack_n1", 32'(note_ack), 1);
        tick;
        check("ack_gap", 32'(note_ack), 0);
        send(1'b0, 15, 4);
        check("ack_n2", 32'(note_ack), 1);
        send(1'b1, 0, 6);
        check("load_all", 32'(voice_load), 7);
        check("ack_adv_word", 32'(note_ack), 0);
        check("notes_s1", 32'(voice_note), vn(12, 15, 0));
        check("durs_s1", 32'(voice_duration), vn(4, 4, 6));
        tick;
        check("load_one_cycle", 32'(voice_load), 0);
        check("adv_on", 32'(advance_time), 1);
        for (int i = 1; i <= 5; i++) begin
            pulse_beat;
            tick;
            check("adv_beats", 32'(advance_time), 1);
            check("ack_beats", 32'(note_ack), 0);
        end
        pulse_beat;
        check("ack_step6", 32'(note_ack), 1);
        check("adv_release", 32'(advance_time), 0);
        tick;
        check("ack_step_end", 32'(note_ack), 0);

        send(1'b0, 20, 3);
        check("ovf_set", 32'(overflow), 1);
        check("ack_ovf", 32'(note_ack), 1);
        check("notes_ovf", 32'(voice_note), vn(12, 15, 0));

        send(1'b1, 0, 2);
        check("load_s3", 32'(voice_load), 7);
        check("durs_busy", 32'(voice_duration), vn(4, 4, 6));
        tick;
        voice_done = 3'b010;
        tick;
        voice_done = '0;
        pulse_beat;
        pulse_beat;
        check("ack_s3", 32'(note_ack), 1);
        tick;
        send(1'b0, 33, 5);
        check("notes_v1", 32'(voice_note), vn(12, 33, 0));
        check("durs_v1", 32'(voice_duration), vn(4, 5, 6));
        check("ovf_sticky", 32'(overflow), 1);
        send(1'b0, 40, 7);
        check("notes_full", 32'(voice_note), vn(12, 33, 0));

        send(1'b1, 0, 3);
        tick;
        check("adv_pre_pause", 32'(advance_time), 1);
        play_enable = 1'b0;
        #1;
        check("adv_pause_now", 32'(advance_time), 0);
        tick;
        for (int i = 0; i < 9; i++) begin
            beat = (i == 3 || i == 7);
            tick;
            check("adv_paused", 32'(advance_time), 0);
        end
        beat = 1'b0;
        play_enable = 1'b1;
        tick;
        check("adv_resume", 32'(advance_time), 1);
        pulse_beat;
        pulse_beat;
        check("ack_early", 32'(note_ack), 0);
        pulse_beat;
        check("ack_pause_step", 32'(note_ack), 1);
        tick;

        send(1'b1, 0, 0);
        tick;
        tick;
        check("d0_ack_idle", 32'(note_ack), 0);
        check("d0_adv", 32'(advance_time), 1);
        pulse_beat;
        check("d0_ack", 32'(note_ack), 1);
        tick;

        send(1'b1, 0, 5);
        tick;
        check("adv_pre_rst", 32'(advance_time), 1);
        reset = 1'b1;
        beat = 1'b1;
        tick;
        reset = 1'b0;
        beat = 1'b0;
        check("mrst_ack", 32'(note_ack), 0);
        check("mrst_adv", 32'(advance_time), 0);
        check("mrst_load", 32'(voice_load), 0);
        check("mrst_note", 32'(voice_note), 0);
        check("mrst_dur", 32'(voice_duration), 0);
        check("mrst_ovf", 32'(overflow), 0);
        tick;
        check("mrst_ack2", 32'(note_ack), 0);
        check("mrst_load2", 32'(voice_load), 0);
        send(1'b0, 9, 2);
        check("post_rst_v0", 32'(voice_note), vn(9, 0, 0));
        send(1'b0, 11, 1);
        check("post_rst_v1", 32'(voice_note), vn(9, 11, 0));
        check("post_rst_dur", 32'(voice_duration), vn(2, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/voice_arranger.md
Name: voice_arranger

Overview:
- Parametrised successor to the three-voice note arranger: buffers up to NUM_VOICES simultaneous notes from the song reader, then releases them together to the note players for a beat-counted time step.
- Sits between the song reader (note words, one-pulse ack) and NUM_VOICES note players (load, note, duration, done).
- Adds over the previous generation: arbitrary voice count and field widths, pending-done capture, overflow flag, and zero-duration handling.

Parameters:
- NUM_VOICES, 3, number of note-player channels (1..8)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width in beat units (48th notes)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- beat  in  1  one-cycle pulse per 48th note
- note_in  in  1+NOTE_W+DUR_W  {is_advance, note, duration}, MSB first
- note_valid  in  1  note_in valid this cycle
- play_enable  in  1  low pauses time advance
- voice_done  in  NUM_VOICES  one-cycle done pulses, bit i = voice i
- voice_load  out  NUM_VOICES  one-cycle load strobes
- voice_note  out  NUM_VOICES*NOTE_W  voice i at [i*NOTE_W +: NOTE_W]
- voice_duration  out  NUM_VOICES*DUR_W  voice i at [i*DUR_W +: DUR_W]
- note_ack  out  1  one-cycle pulse to song reader, registered
- advance_time  out  1  high while note players should run
- overflow  out  1  sticky: note dropped because all voices were busy

Behaviour:
- Reset: state ASSIGN, busy=0, done_pending=0, count=0, all voice_note/voice_duration=0, voice_load=0, note_ack=0, advance_time=0, overflow=0. Reset mid-operation aborts immediately; no load or ack is issued afterwards.
- States: ASSIGN, LOAD, ADVANCE, PAUSE, RELEASE.
- note_valid is honoured only in ASSIGN and ignored in all other states.
- ASSIGN, note word (is_advance=0):
  - Store note and duration in the lowest-index voice with busy=0, then set that busy bit.
  - If all voices are busy, drop the note and set overflow.
  - Stay in ASSIGN. note_ack pulses 1 cycle after acceptance in both cases.
- ASSIGN, advance word (is_advance=1), duration D:
  - Every non-busy voice gets note=0 (rest) and duration=D, and its busy bit is set.
  - count = D-1. D=0 is treated as D=1, so count=0.
  - Go to LOAD. No ack is issued here.
- LOAD: voice_load = all ones for exactly 1 cycle, then ADVANCE.
- ADVANCE: advance_time=1. Checks in priority order:
  1. beat & count==0: go to RELEASE; note_ack pulses next cycle.
  2. !play_enable: go to PAUSE; advance_time=0 in this same cycle.
  3. beat: count -= 1.
  4. Otherwise hold.
- PAUSE: advance_time=0, count held, beats ignored. play_enable=1 returns to ADVANCE.
- voice_done capture:
  - done_pending |= voice_done in every state, so a pulse arriving in any cycle is never lost.
  - RELEASE lasts 1 cycle: busy &= ~done_pending, done_pending is cleared (except pulses arriving that same cycle, which are kept), then ASSIGN.
- Arithmetic: count is DUR_W bits with no wrap; decrement happens only when count>0.
- overflow clears only on reset.

Optional Feature:
ALLOC_ROUND_ROBIN_EN
- Defined: free-voice search starts at a rotating pointer. The pointer advances to (allocated index+1) mod NUM_VOICES on each allocation and resets to 0.
- Undefined: fixed lowest-index-first allocation as above.

Test Plan:
- N=3. Notes {0,12,4}, {0,15,4}, then advance {1,x,6}: voice_note=12,15,0, durations 4,4,6; voice_load=111 one cycle; two note_acks during assign; advance_time high for 6 beats; note_ack 1 cycle after the 6th beat.
- All 3 voices busy, 4th note word: overflow=1, note_ack still pulses, voice registers unchanged.
- voice_done[1] pulsed mid-ADVANCE, then step completes: after RELEASE busy=101; the next note lands in voice 1.
- play_enable low for 10 cycles spanning 2 beats during ADVANCE: advance_time=0 throughout; count unchanged; total ADVANCE still consumes exactly D beats.
- Advance word with D=0: count=0; first beat in ADVANCE leads to RELEASE and note_ack.
- reset asserted in ADVANCE: next cycle state ASSIGN, all outputs 0, no note_ack; with ALLOC_ROUND_ROBIN_EN the pointer returns to 0.
